fetch_pc_unit: RTL and testbench

//  Fetch stage that feeds ControlUnit_FSM. Owns the program counter, instruction register and N/Z flags.

---
 rtl/fetch_pc_unit.sv | 128 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch stage for the control FSM: owns the program counter, the instruction register
// and the N/Z flags, and answers the FSM with op_code and the CMOV condition.
module fetch_pc_unit #(
    parameter int unsigned          PC_W     = 32,
    parameter int unsigned          INSTR_W  = 32,
    parameter int unsigned          OFF_W    = 16,
    parameter logic [PC_W-1:0]      RESET_PC = '0,
    parameter int unsigned          DATA_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               loadPC,
    input  logic [2:0]         BRANCH,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               flag_we,
    output logic [PC_W-1:0]    imem_addr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         op_code,
    output logic               flag_n,
    output logic               flag_z,
    output logic               cmov_take,
    output logic               halted
);

    typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} phase_t;

    typedef enum logic [2:0] {
        BR_NONE   = 3'b000,
        BR_ALWAYS = 3'b001,
        BR_MI     = 3'b010,
        BR_PL     = 3'b011,
        BR_Z      = 3'b100,
        BR_CMOV   = 3'b101
    } branch_t;

    localparam logic [INSTR_W-1:0] NOP_INSTR = {4'hE, {(INSTR_W-4){1'b0}}};
    localparam logic [3:0]         OP_HALT   = 4'hF;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    phase_t             phase_q, phase_d;
    logic               redirect_q, redirect_d;
    logic               flag_n_q, flag_n_d;
    logic               flag_z_q, flag_z_d;
    logic               halted_q, halted_d;
    logic               branch_taken;
    logic [PC_W-1:0]    br_offset;

    assign br_offset = {{(PC_W-OFF_W){instr_q[OFF_W-1]}}, instr_q[OFF_W-1:0]};

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        branch_taken = 1'b0;
        case (BRANCH)
            BR_ALWAYS: branch_taken = 1'b1;
            BR_MI:     branch_taken = flag_n_q;
            BR_PL:     branch_taken = ~flag_n_q;
            BR_Z:      branch_taken = flag_z_q;
            default:   branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        phase_d    = phase_q;
        redirect_d = redirect_q;
        flag_n_d   = flag_n_q;
        flag_z_d   = flag_z_q;
        halted_d   = halted_q | (instr_q[INSTR_W-1 -: 4] == OP_HALT);

        // Flags track the datapath even while halted; branches below read the pre-edge values.
        if (flag_we) begin
            flag_n_d = alu_result[DATA_W-1];
            flag_z_d = (alu_result == '0);
        end

        if (loadPC && !halted_q) begin
            if (BRANCH == BR_NONE) begin
                if (phase_q == FETCH) begin
                    instr_d = imem_data;
                    phase_d = EXEC;
                end else begin
                    phase_d = FETCH;
                    // A taken branch already moved pc, so the closing update only clears the redirect.
                    if (redirect_q) redirect_d = 1'b0;
                    else            pc_d       = pc_q + PC_W'(1);
                end
            end else if (phase_q == EXEC && branch_taken) begin
                pc_d       = pc_q + br_offset;
                redirect_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            phase_q    <= FETCH;
            redirect_q <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            phase_q    <= phase_d;
            redirect_q <= redirect_d;
            flag_n_q   <= flag_n_d;
            flag_z_q   <= flag_z_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign op_code   = instr_q[INSTR_W-1 -: 4];
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
    assign halted    = halted_q;
    assign cmov_take = (BRANCH == BR_CMOV) && flag_n_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboarded bench for fetch_pc_unit: each scenario queues the expected architectural
// state for every strobe, a snapshot is taken after each edge, and the queues are compared.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        loadPC = 1'b0;
    logic [2:0]  BRANCH = 3'b000;
    logic [31:0] imem_data = 32'hE000_0000;
    logic [31:0] alu_result = '0;
    logic        flag_we = 1'b0;
    logic [31:0] imem_addr, pc, instr;
    logic [3:0]  op_code;
    logic        flag_n, flag_z, cmov_take, halted;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fn;
        logic        fz;
        logic        halt;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    string name_q[$];

    localparam logic [2:0] NONE = 3'b000, BR = 3'b001, BMI = 3'b010, BPL = 3'b011,
                           BZ = 3'b100, CMOV = 3'b101;
    localparam logic [31:0] NOP = 32'hE000_0000;

    fetch_pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .loadPC     (loadPC),
        .BRANCH     (BRANCH),
        .imem_data  (imem_data),
        .alu_result (alu_result),
        .flag_we    (flag_we),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .instr      (instr),
        .op_code    (op_code),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .cmov_take  (cmov_take),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input logic [31:0] p, input logic [31:0] i,
                                 input logic n, input logic z, input logic h);
        mk = '{pc: p, instr: i, fn: n, fz: z, halt: h};
    endfunction

    // One clock of stimulus; the DUT state is snapshotted 1 ns after the edge.
    task automatic pulse(input string nm, input logic ld, input logic [2:0] br,
                         input logic fwe, input logic [31:0] alu, input snap_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        loadPC = ld; BRANCH = br; flag_we = fwe; alu_result = alu;
        @(posedge clk);
        #1;
        obs_q.push_back('{pc: pc, instr: instr, fn: flag_n, fz: flag_z, halt: halted});
        loadPC = 1'b0; BRANCH = NONE; flag_we = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        exp_q.push_back(mk(32'd0, NOP, 1'b0, 1'b0, 1'b0));
        name_q.push_back(nm);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        obs_q.push_back('{pc: pc, instr: instr, fn: flag_n, fz: flag_z, halt: halted});
        reset = 1'b0;
    endtask

    task automatic drain(input string scen);
        while (exp_q.size() > 0) begin
            snap_t e, o;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL %s/%s: no observation captured", scen, nm);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s/%s: got pc=%h instr=%h n=%b z=%b h=%b, want pc=%h instr=%h n=%b z=%b h=%b",
                             scen, nm, o.pc, o.instr, o.fn, o.fz, o.halt,
                             e.pc, e.instr, e.fn, e.fz, e.halt);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset;
        do_reset("reset");
        drain("reset");
        checks++;
        if (op_code !== 4'hE || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset/outputs: op_code=%h imem_addr=%h, want E and 0", op_code, imem_addr);
        end
    endtask

    task automatic test_fetch_update;
        imem_data = 32'h0123_4567;
        pulse("fetch", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'h0123_4567, 0, 0, 0));
        checks++;
        if (op_code !== 4'h0) begin
            errors++;
            $display("FAIL fetch/op_code: got %h want 0", op_code);
        end
        pulse("update", 1'b1, NONE, 1'b0, '0, mk(32'd1, 32'h0123_4567, 0, 0, 0));
        checks++;
        if (imem_addr !== 32'd1) begin
            errors++;
            $display("FAIL fetch/imem_addr: got %h want 1", imem_addr);
        end
        drain("fetch_update");
    endtask

    task automatic test_branch_taken;
        do_reset("reset");
        imem_data = 32'h1000_000A;
        pulse("fetch_br", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'h1000_000A, 0, 0, 0));
        pulse("br+10", 1'b1, BR, 1'b0, '0, mk(32'd10, 32'h1000_000A, 0, 0, 0));
        pulse("upd_hold", 1'b1, NONE, 1'b0, '0, mk(32'd10, 32'h1000_000A, 0, 0, 0));
        pulse("set_z", 1'b0, NONE, 1'b1, 32'd0, mk(32'd10, 32'h1000_000A, 0, 1, 0));
        imem_data = 32'h4000_FFFC;
        pulse("fetch_bz", 1'b1, NONE, 1'b0, '0, mk(32'd10, 32'h4000_FFFC, 0, 1, 0));
        pulse("bz-4", 1'b1, BZ, 1'b0, '0, mk(32'd6, 32'h4000_FFFC, 0, 1, 0));
        pulse("upd_hold", 1'b1, NONE, 1'b0, '0, mk(32'd6, 32'h4000_FFFC, 0, 1, 0));
        imem_data = NOP;
        pulse("fetch_nop", 1'b1, NONE, 1'b0, '0, mk(32'd6, NOP, 0, 1, 0));
        pulse("upd_cleared", 1'b1, NONE, 1'b0, '0, mk(32'd7, NOP, 0, 1, 0));
        drain("branch_taken");
    endtask

    task automatic test_branch_not_taken;
        do_reset("reset");
        imem_data = 32'h1000_000A;
        pulse("fetch_br", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'h1000_000A, 0, 0, 0));
        pulse("br+10", 1'b1, BR, 1'b0, '0, mk(32'd10, 32'h1000_000A, 0, 0, 0));
        pulse("upd_hold", 1'b1, NONE, 1'b0, '0, mk(32'd10, 32'h1000_000A, 0, 0, 0));
        imem_data = 32'h2000_0005;
        pulse("fetch_bmi", 1'b1, NONE, 1'b0, '0, mk(32'd10, 32'h2000_0005, 0, 0, 0));
        pulse("bmi_n0", 1'b1, BMI, 1'b0, '0, mk(32'd10, 32'h2000_0005, 0, 0, 0));
        pulse("upd_inc", 1'b1, NONE, 1'b0, '0, mk(32'd11, 32'h2000_0005, 0, 0, 0));
        drain("branch_not_taken");
    endtask

    task automatic test_wrap;
        do_reset("reset");
        imem_data = 32'h1000_FFFF;
        pulse("fetch_m1", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'h1000_FFFF, 0, 0, 0));
        pulse("br-1", 1'b1, BR, 1'b0, '0, mk(32'hFFFF_FFFF, 32'h1000_FFFF, 0, 0, 0));
        pulse("upd_hold", 1'b1, NONE, 1'b0, '0, mk(32'hFFFF_FFFF, 32'h1000_FFFF, 0, 0, 0));
        imem_data = NOP;
        pulse("fetch_nop", 1'b1, NONE, 1'b0, '0, mk(32'hFFFF_FFFF, NOP, 0, 0, 0));
        pulse("upd_wrap", 1'b1, NONE, 1'b0, '0, mk(32'd0, NOP, 0, 0, 0));
        do_reset("reset2");
        imem_data = 32'h1000_FFFE;
        pulse("fetch_m2", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'h1000_FFFE, 0, 0, 0));
        pulse("br-2", 1'b1, BR, 1'b0, '0, mk(32'hFFFF_FFFE, 32'h1000_FFFE, 0, 0, 0));
        pulse("upd_hold", 1'b1, NONE, 1'b0, '0, mk(32'hFFFF_FFFE, 32'h1000_FFFE, 0, 0, 0));
        imem_data = 32'h1000_0003;
        pulse("fetch_p3", 1'b1, NONE, 1'b0, '0, mk(32'hFFFF_FFFE, 32'h1000_0003, 0, 0, 0));
        pulse("br+3_wrap", 1'b1, BR, 1'b0, '0, mk(32'd1, 32'h1000_0003, 0, 0, 0));
        drain("wrap");
    endtask

    task automatic test_flags_and_ignored;
        do_reset("reset");
        imem_data = 32'h3000_0004;
        pulse("fetch_bpl", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'h3000_0004, 0, 0, 0));
        pulse("bpl_oldN", 1'b1, BPL, 1'b1, 32'h8000_0000, mk(32'd4, 32'h3000_0004, 1, 0, 0));
        @(negedge clk);
        BRANCH = CMOV;
        #1;
        checks++;
        if (cmov_take !== 1'b1) begin
            errors++;
            $display("FAIL flags/cmov_take: got %b want 1", cmov_take);
        end
        BRANCH = NONE;
        pulse("cmov_ignored", 1'b1, CMOV, 1'b0, '0, mk(32'd4, 32'h3000_0004, 1, 0, 0));
        pulse("rsvd_ignored", 1'b1, 3'b111, 1'b0, '0, mk(32'd4, 32'h3000_0004, 1, 0, 0));
        pulse("upd_hold", 1'b1, NONE, 1'b0, '0, mk(32'd4, 32'h3000_0004, 1, 0, 0));
        pulse("br_in_fetch", 1'b1, BR, 1'b0, '0, mk(32'd4, 32'h3000_0004, 1, 0, 0));
        pulse("flag_pos", 1'b0, NONE, 1'b1, 32'h0000_0001, mk(32'd4, 32'h3000_0004, 0, 0, 0));
        drain("flags");
        checks++;
        if (cmov_take !== 1'b0) begin
            errors++;
            $display("FAIL flags/cmov_idle: got %b want 0", cmov_take);
        end
    endtask

    task automatic test_halt_and_reset;
        do_reset("reset");
        imem_data = 32'hF000_0000;
        pulse("fetch_halt", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'hF000_0000, 0, 0, 0));
        pulse("halt_latch", 1'b0, NONE, 1'b0, '0, mk(32'd0, 32'hF000_0000, 0, 0, 1));
        pulse("frozen_upd", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'hF000_0000, 0, 0, 1));
        imem_data = NOP;
        pulse("frozen_fetch", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'hF000_0000, 0, 0, 1));
        pulse("halted_flags", 1'b1, BR, 1'b1, 32'd0, mk(32'd0, 32'hF000_0000, 0, 1, 1));
        do_reset("reset_clears");
        // Reset while a taken branch is pending must drop the redirect.
        imem_data = 32'h1000_0005;
        pulse("fetch_br", 1'b1, NONE, 1'b0, '0, mk(32'd0, 32'h1000_0005, 0, 0, 0));
        pulse("br+5", 1'b1, BR, 1'b0, '0, mk(32'd5, 32'h1000_0005, 0, 0, 0));
        do_reset("reset_mid");
        imem_data = NOP;
        pulse("fetch_nop", 1'b1, NONE, 1'b0, '0, mk(32'd0, NOP, 0, 0, 0));
        pulse("upd_inc", 1'b1, NONE, 1'b0, '0, mk(32'd1, NOP, 0, 0, 0));
        drain("halt");
    endtask

    initial begin
        test_reset();
        test_fetch_update();
        test_branch_taken();
        test_branch_not_taken();
        test_wrap();
        test_flags_and_ignored();
        test_halt_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
